// File: rtl/tpu_pkg.sv
// Shared definitions for the Mini TPU: opcodes, instruction field positions and
// the command sequencer state encoding.
package tpu_pkg;

   localparam int unsigned INSTR_W   = 16;
   localparam int unsigned RUN_CNT_W = 4;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_STORE = 2'b11;

   localparam int unsigned OP_MSB  = 15;
   localparam int unsigned OP_LSB  = 14;
   localparam int unsigned IMM_LSB = 0;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StStore,
      StResp
   } state_e;

   function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] instr);
      return instr[OP_MSB:OP_LSB];
   endfunction

   // A zero count in imm[3:0] selects the configured default hold length.
   function automatic logic [RUN_CNT_W-1:0] instr_run_len(input logic [INSTR_W-1:0]   instr,
                                                          input logic [RUN_CNT_W-1:0] dflt);
      logic [RUN_CNT_W-1:0] imm_cnt;
      imm_cnt = instr[IMM_LSB +: RUN_CNT_W];
      return (imm_cnt == '0) ? dflt : imm_cnt;
   endfunction

endpackage

// File: rtl/tpu_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full and pop when empty.
module tpu_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/tpu_sequencer.sv
// Command sequencer: pops host instructions from a FIFO, drives them onto the control
// unit bus (RUN held for a counted length) and returns STORE results over valid/ready.
module tpu_sequencer
   import tpu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RUN_CYCLES = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [15:0]                   cmd_data,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   output logic [15:0]                   instr_out,
   input  logic [DATA_WIDTH-1:0]         result_in,
   output logic [DATA_WIDTH-1:0]         res_data,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic                          busy,
   output logic                          run_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam logic [RUN_CNT_W-1:0] RUN_DEFAULT = RUN_CNT_W'(RUN_CYCLES);

   state_e                 state_q, state_d;
   logic [INSTR_W-1:0]     instr_q, instr_d;
   logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
   logic [DATA_WIDTH-1:0]  res_data_q, res_data_d;
   logic                   res_valid_q, res_valid_d;

   logic [INSTR_W-1:0]     fifo_rdata;
   logic                   fifo_full, fifo_empty, fifo_pop;

   tpu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INSTR_W)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .wdata (cmd_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      run_cnt_d   = run_cnt_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      fifo_pop    = 1'b0;
      unique case (state_q)
         StIdle: begin
            instr_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               unique case (instr_op(fifo_rdata))
                  OP_RUN: begin
                     state_d   = StRun;
                     instr_d   = fifo_rdata;
                     run_cnt_d = instr_run_len(fifo_rdata, RUN_DEFAULT);
                  end
                  OP_LOAD: begin
                     state_d = StLoad;
                     instr_d = fifo_rdata;
                  end
                  OP_STORE: begin
                     state_d = StStore;
                     instr_d = fifo_rdata;
                  end
                  default: begin
                     // NOP is consumed here without ever reaching the bus.
                     state_d = StIdle;
                  end
               endcase
            end
         end
         StLoad: begin
            state_d = StIdle;
            instr_d = '0;
         end
         StRun: begin
            if (run_cnt_q <= 4'd1) begin
               state_d = StIdle;
               instr_d = '0;
            end else begin
               run_cnt_d = run_cnt_q - 1'b1;
            end
         end
         StStore: begin
            state_d     = StResp;
            instr_d     = '0;
            res_data_d  = result_in;
            res_valid_d = 1'b1;
         end
         StResp: begin
            instr_d = '0;
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            instr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         instr_q     <= '0;
         run_cnt_q   <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         run_cnt_q   <= run_cnt_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign instr_out = instr_q;
   assign res_data  = res_data_q;
   assign res_valid = res_valid_q;
   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != StIdle) || !fifo_empty;
   assign run_done  = (state_q == StRun) && (run_cnt_q == 4'd1);

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer: vector table plus hand sequences, with a
// bus/result scoreboard fed at push time and drained by a negedge monitor.
module tb_tpu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cmd_data = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] instr_out;
   logic [7:0]  result_in = '0;
   logic [7:0]  res_data;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        busy;
   logic        run_done;
   logic [2:0]  fifo_count;

   tpu_sequencer #(
      .DATA_WIDTH (8),
      .FIFO_DEPTH (4),
      .RUN_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .instr_out  (instr_out),
      .result_in  (result_in),
      .res_data   (res_data),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .busy       (busy),
      .run_done   (run_done),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] cmd;
      int          len;
   } bus_t;

   typedef struct {
      logic [15:0] cmd;
      int          len;
      logic [7:0]  res;
      int          hold;
   } vec_t;

   bus_t       exp_q[$];
   logic [7:0] res_q[$];
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_cmd(input logic [15:0] d);
      int n = 0;
      cmd_data  = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("push_accept", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic issue(input logic [15:0] d, input int len, input logic [7:0] res);
      bus_t b;
      b.cmd = d;
      b.len = len;
      if (len > 0) exp_q.push_back(b);
      if (d[15:14] == 2'b11) res_q.push_back(res);
      push_cmd(d);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_idle", busy, 0);
   endtask

   task automatic wait_res_valid();
      int n = 0;
      while (!res_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_res_valid", res_valid, 1);
   endtask

   task automatic serve_result(input int hold);
      wait_res_valid();
      repeat (hold) begin
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   // Bus and result monitor, sampling mid-cycle.
   initial begin
      bus_t       cur;
      int         cur_len;
      logic [15:0] prev_instr;
      logic       prev_valid, prev_ready;
      logic [7:0] prev_data;
      cur.cmd = '0; cur.len = 0; cur_len = 0;
      prev_instr = '0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            res_q.delete();
            prev_instr = '0;
            prev_valid = 1'b0;
            cur_len    = 0;
         end else begin
            if (instr_out != 16'h0000) begin
               if (prev_instr == 16'h0000) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_issue", instr_out, 0);
                     cur.cmd = instr_out;
                     cur.len = 0;
                  end else begin
                     cur = exp_q.pop_front();
                     check("issue_order", instr_out, cur.cmd);
                  end
                  cur_len = 1;
               end else begin
                  check("hold_value", instr_out, prev_instr);
                  cur_len++;
               end
               check("run_done", run_done, (cur.cmd[15:14] == 2'b01) && (cur_len == cur.len));
            end else begin
               if (prev_instr != 16'h0000) check("burst_len", cur_len, cur.len);
               check("run_done_idle", run_done, 0);
            end
            prev_instr = instr_out;
            if (prev_valid && !prev_ready) begin
               check("res_hold", {res_valid, res_data}, {1'b1, prev_data});
            end
            if (res_valid && res_ready) begin
               if (res_q.size() == 0) check("unexpected_result", res_valid, 0);
               else check("result", res_data, res_q.pop_front());
            end
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_data  = res_data;
         end
      end
   end

   initial begin
      vec_t vecs[7];
      int   n;
      vecs[0] = '{cmd: 16'h8A5C, len: 1,  res: 8'h00, hold: 0};
      vecs[1] = '{cmd: 16'h4003, len: 3,  res: 8'h00, hold: 0};
      vecs[2] = '{cmd: 16'h4000, len: 8,  res: 8'h00, hold: 0};
      vecs[3] = '{cmd: 16'h400F, len: 15, res: 8'h00, hold: 0};
      vecs[4] = '{cmd: 16'hD900, len: 1,  res: 8'hE7, hold: 2};
      vecs[5] = '{cmd: 16'h8100, len: 1,  res: 8'h00, hold: 0};
      vecs[6] = '{cmd: 16'h4021, len: 1,  res: 8'h00, hold: 0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_instr", instr_out, 16'h0000);
      check("rst_res_data", res_data, 8'h00);
      check("rst_res_valid", res_valid, 0);
      check("rst_run_done", run_done, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // LOAD latency and single-cycle width
      issue(16'h8A5C, 1, 8'h00);
      check("t1_before", instr_out, 16'h0000);
      @(posedge clk); #1;
      check("t1_issue", instr_out, 16'h8A5C);
      @(posedge clk); #1;
      check("t1_after", instr_out, 16'h0000);
      wait_idle();

      // Vector table
      for (int i = 0; i < 7; i++) begin
         result_in = vecs[i].res;
         issue(vecs[i].cmd, vecs[i].len, vecs[i].res);
         if (vecs[i].cmd[15:14] == 2'b11) serve_result(vecs[i].hold);
         wait_idle();
      end

      // STORE with a slow consumer
      result_in = 8'h3B;
      issue(16'hC600, 1, 8'h3B);
      wait_res_valid();
      result_in = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t3_valid_held", res_valid, 1);
         check("t3_data_held", res_data, 8'h3B);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("t3_valid_drop", res_valid, 0);
      wait_idle();

      // Fill the FIFO while waiting in RESP, then drain
      result_in = 8'h5A;
      issue(16'hC700, 1, 8'h5A);
      wait_res_valid();
      issue(16'h8111, 1, 8'h00);
      issue(16'h4002, 2, 8'h00);
      issue(16'h8222, 1, 8'h00);
      issue(16'h4001, 1, 8'h00);
      check("t4_count_full", fifo_count, 4);
      check("t4_ready_low", cmd_ready, 0);
      cmd_data  = 16'h8444;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("t4_no_overflow", fifo_count, 4);
      check("t4_still_resp", res_valid, 1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      issue(16'h8444, 1, 8'h00);
      wait_idle();

      // NOP is dropped without a bus cycle
      issue(16'h0000, 0, 8'h00);
      issue(16'h8C3C, 1, 8'h00);
      check("t5_gap", instr_out, 16'h0000);
      @(posedge clk); #1;
      check("t5_load", instr_out, 16'h8C3C);
      wait_idle();

      // Reset in the second RUN cycle
      issue(16'h4005, 5, 8'h00);
      n = 0;
      while (instr_out != 16'h4005 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("t6_run_start", instr_out, 16'h4005);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("t6_instr", instr_out, 16'h0000);
      check("t6_run_done", run_done, 0);
      check("t6_busy", busy, 0);
      check("t6_fifo_count", fifo_count, 0);
      check("t6_cmd_ready", cmd_ready, 1);
      check("t6_res_valid", res_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("t6_post_instr", instr_out, 16'h0000);
      issue(16'h8F0F, 1, 8'h00);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;

      check("exp_queue_empty", exp_q.size(), 0);
      check("res_queue_empty", res_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
